// File: rtl/oled_spi_phy.sv
// PmodOLEDrgb (SSD1331) physical layer: power-up/reset sequencing plus a
// byte-wide SPI mode-3 transmitter with a latched D/C flag.
module oled_spi_phy #(
    parameter int CLK_DIV   = 8,
    parameter int PWR_WAIT  = 2_000_000,
    parameter int RST_PULSE = 300,
    parameter int RST_WAIT  = 300
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_dc,
    input  logic       vcc_req,
    output logic       init_done,
    output logic       cs,
    output logic       mosi,
    output logic       sclk,
    output logic       dc,
    output logic       res_n,
    output logic       vcc_en,
    output logic       pmoden
);
    localparam int MAX_A = (PWR_WAIT > RST_PULSE) ? PWR_WAIT : RST_PULSE;
    localparam int MAX_B = (RST_WAIT > CLK_DIV) ? RST_WAIT : CLK_DIV;
    localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAX_P) + 1;

    // PWR compares against PWR_WAIT (not -1): pmoden only rises on the first
    // edge after reset, so PWR spans one extra cycle to give PWR_WAIT of pmoden.
    localparam logic [CW-1:0] PWR_LAST     = CW'(PWR_WAIT);
    localparam logic [CW-1:0] RST_LO_LAST  = CW'(RST_PULSE - 1);
    localparam logic [CW-1:0] RST_REC_LAST = CW'(RST_WAIT - 1);
    localparam logic [CW-1:0] HALF_LAST    = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_ONE      = CW'(1);

    typedef enum logic [2:0] {
        ST_PWR,
        ST_RST_LO,
        ST_RST_REC,
        ST_IDLE,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [3:0]      half_reg, half_next;
    logic [6:0]      shift_reg, shift_next;
    logic            sclk_reg, sclk_next;
    logic            mosi_reg, mosi_next;
    logic            dc_reg, dc_next;
    logic            cs_reg, cs_next;
    logic            res_n_reg, res_n_next;
    logic            init_done_reg, init_done_next;
    logic            pmoden_reg;
    logic            vcc_en_reg;
    logic            cnt_done;
    logic            accept;

    always_comb begin
        cnt_done = 1'b0;
        case (state_reg)
            ST_PWR:                    cnt_done = (cnt_reg == PWR_LAST);
            ST_RST_LO:                 cnt_done = (cnt_reg == RST_LO_LAST);
            ST_RST_REC:                cnt_done = (cnt_reg == RST_REC_LAST);
            ST_SHIFT, ST_HOLD, ST_GAP: cnt_done = (cnt_reg == HALF_LAST);
            default:                   cnt_done = 1'b0;
        endcase
    end

    // Ready is raised in the last cycle of RST_REC/GAP so the accept lands on
    // the same edge that would enter IDLE, keeping the byte period at 18*CLK_DIV.
    assign tx_ready = (state_reg == ST_IDLE) ||
                      (cnt_done && (state_reg == ST_RST_REC || state_reg == ST_GAP));
    assign accept   = tx_valid && tx_ready;

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        half_next      = half_reg;
        shift_next     = shift_reg;
        sclk_next      = sclk_reg;
        mosi_next      = mosi_reg;
        dc_next        = dc_reg;
        cs_next        = cs_reg;
        res_n_next     = res_n_reg;
        init_done_next = init_done_reg;
        case (state_reg)
            ST_PWR: begin
                if (cnt_done) begin
                    state_next = ST_RST_LO;
                    cnt_next   = '0;
                    res_n_next = 1'b0;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            ST_RST_LO: begin
                if (cnt_done) begin
                    state_next = ST_RST_REC;
                    cnt_next   = '0;
                    res_n_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            ST_RST_REC: begin
                if (cnt_done) begin
                    state_next     = ST_IDLE;
                    cnt_next       = '0;
                    init_done_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            ST_IDLE: begin
            end
            ST_SHIFT: begin
                if (cnt_done) begin
                    cnt_next = '0;
                    if (!half_reg[0]) begin
                        // Falling edge: present the next bit (bit 7 is already out).
                        sclk_next = 1'b0;
                        half_next = half_reg + 4'd1;
                        if (half_reg != 4'd0) begin
                            mosi_next  = shift_reg[6];
                            shift_next = {shift_reg[5:0], 1'b0};
                        end
                    end else if (half_reg == 4'd15) begin
                        sclk_next  = 1'b1;
                        half_next  = '0;
                        state_next = ST_HOLD;
                    end else begin
                        sclk_next = 1'b1;
                        half_next = half_reg + 4'd1;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            ST_HOLD: begin
                if (cnt_done) begin
                    state_next = ST_GAP;
                    cnt_next   = '0;
                    cs_next    = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            ST_GAP: begin
                if (cnt_done) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            default: state_next = ST_PWR;
        endcase

        if (accept) begin
            state_next = ST_SHIFT;
            cnt_next   = '0;
            half_next  = '0;
            shift_next = tx_data[6:0];
            mosi_next  = tx_data[7];
            dc_next    = tx_dc;
            cs_next    = 1'b0;
            sclk_next  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_PWR;
            cnt_reg       <= '0;
            half_reg      <= '0;
            shift_reg     <= '0;
            sclk_reg      <= 1'b1;
            mosi_reg      <= 1'b0;
            dc_reg        <= 1'b0;
            cs_reg        <= 1'b1;
            res_n_reg     <= 1'b1;
            init_done_reg <= 1'b0;
            pmoden_reg    <= 1'b0;
            vcc_en_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            half_reg      <= half_next;
            shift_reg     <= shift_next;
            sclk_reg      <= sclk_next;
            mosi_reg      <= mosi_next;
            dc_reg        <= dc_next;
            cs_reg        <= cs_next;
            res_n_reg     <= res_n_next;
            init_done_reg <= init_done_next;
            pmoden_reg    <= 1'b1;
            vcc_en_reg    <= vcc_req && init_done_reg;
        end
    end

    assign init_done = init_done_reg;
    assign cs        = cs_reg;
    assign mosi      = mosi_reg;
    assign sclk      = sclk_reg;
    assign dc        = dc_reg;
    assign res_n     = res_n_reg;
    assign vcc_en    = vcc_en_reg;
    assign pmoden    = pmoden_reg;
endmodule

// File: tb/tb_oled_spi_phy.sv
// Bench for oled_spi_phy: timeline model (edge arithmetic) checked every cycle,
// SPI mode-3 frame decoder, and literal power-up/transfer timing checks.
module tb_oled_spi_phy;
    localparam int D      = 2;
    localparam int PW     = 10;
    localparam int RP     = 4;
    localparam int RW     = 5;
    localparam int T_INIT = 1 + PW + RP + RW;
    localparam int NRAND  = 8;

    logic       clk, rst, tx_valid, tx_ready, tx_dc, vcc_req;
    logic       init_done, cs, mosi, sclk, dc, res_n, vcc_en, pmoden;
    logic [7:0] tx_data;

    int checks = 0;
    int failures = 0;

    // Model state: edges since rst release, accept edge of latest byte.
    int         n = 0;
    int         e0 = -1;
    logic [7:0] mbyte = 8'h00;
    logic       mdc = 1'b0;
    logic       vcc_exp = 1'b0;
    logic [7:0] exp_q[$];

    int         mon_bits = 0;
    int         frames = 0;
    logic [7:0] mon_sh = 8'h00;

    oled_spi_phy #(.CLK_DIV(D), .PWR_WAIT(PW), .RST_PULSE(RP), .RST_WAIT(RW)) dut (
        .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_data(tx_data), .tx_dc(tx_dc), .vcc_req(vcc_req), .init_done(init_done),
        .cs(cs), .mosi(mosi), .sclk(sclk), .dc(dc), .res_n(res_n),
        .vcc_en(vcc_en), .pmoden(pmoden)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    function automatic bit ready_at(input int k);
        return (k >= T_INIT) && !(e0 >= 0 && k < e0 + 18 * D);
    endfunction

    function automatic int exp_cs();
        return (e0 >= 0 && (n - e0) < 17 * D) ? 0 : 1;
    endfunction

    function automatic int exp_sclk();
        int k;
        k = n - e0;
        return (e0 >= 0 && k < 16 * D && ((k / D) % 2) == 1) ? 0 : 1;
    endfunction

    function automatic int exp_mosi();
        int k, idx;
        if (e0 < 0) return 0;
        k   = n - e0;
        idx = (k < D) ? 0 : (k / D - 1) / 2;
        if (idx > 7) idx = 7;
        return int'(mbyte[7 - idx]);
    endfunction

    // Behavioural model advanced on every edge.
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                n = 0; e0 = -1; mbyte = 8'h00; mdc = 1'b0; vcc_exp = 1'b0;
                exp_q.delete();
            end else begin
                vcc_exp = vcc_req && (n >= T_INIT);
                n++;
                if (tx_valid && ready_at(n)) begin
                    e0 = n; mbyte = tx_data; mdc = tx_dc;
                    exp_q.push_back(tx_data);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("pmoden", pmoden, int'(n >= 1));
            chk("res_n", res_n, int'(!(n >= 1 + PW && n < 1 + PW + RP)));
            chk("init_done", init_done, int'(n >= T_INIT));
            chk("tx_ready", tx_ready, int'(ready_at(n + 1)));
            chk("cs", cs, exp_cs());
            chk("sclk", sclk, exp_sclk());
            chk("mosi", mosi, exp_mosi());
            chk("dc", dc, int'(mdc));
            chk("vcc_en", vcc_en, int'(vcc_exp));
        end
    end

    // Mode-3 SPI decoder: sample mosi on rising sclk while cs is low.
    initial begin
        forever begin
            @(posedge sclk);
            if (cs === 1'b0 && !rst) begin
                mon_sh = {mon_sh[6:0], mosi};
                mon_bits++;
            end else if (!rst) begin
                checks++; failures++;
                $display("FAIL sclk_rise_cs_high t=%0t actual=cs%0b required=cs0", $time, cs);
            end
        end
    end

    initial begin
        forever begin
            @(posedge cs);
            if (!rst) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL frame_unexpected t=%0t actual=%02h required=none", $time, mon_sh);
                end else begin
                    chk("frame_bits", mon_bits, 8);
                    chk("frame_byte", mon_sh, exp_q.pop_front());
                end
                frames++;
            end
            mon_bits = 0;
        end
    end

    initial begin
        forever begin
            @(posedge rst);
            mon_bits = 0;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog t=%0t actual=running required=finished", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic wait_ready(input string what);
        int t;
        t = 0;
        while (!tx_ready && t < 400) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (!tx_ready) begin
            failures++;
            $display("FAIL timeout_%s t=%0t actual=tx_ready0 required=tx_ready1", what, $time);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic d);
        wait_ready("send");
        tx_data  = b;
        tx_dc    = d;
        tx_valid = 1'b1;
        @(posedge clk);
        #2 tx_valid = 1'b0;
    endtask

    // Literal power-up timeline; called right after rst is released.
    task automatic powerup(input bit early);
        for (int k = 0; k <= 21; k++) begin
            @(negedge clk);
            if (k < 20) begin
                chk("pu_cs_high", cs, 1);
                chk("pu_sclk_high", sclk, 1);
            end
            if (k == 0) chk("pu_pmoden_e0", pmoden, 0);
            if (k == 1) chk("pu_pmoden_e1", pmoden, 1);
            if (k == 10) chk("pu_res_n_e10", res_n, 1);
            if (k == 11 || k == 14) chk("pu_res_n_low", res_n, 0);
            if (k == 15) chk("pu_res_n_e15", res_n, 1);
            if (k == 19) begin
                chk("pu_init_e19", init_done, 0);
                chk("pu_ready_at_e20", tx_ready, 1);
            end
            if (k == 20) begin
                chk("pu_init_e20", init_done, 1);
                chk("pu_vcc_e20", vcc_en, 0);
                chk("pu_cs_e20", cs, early ? 0 : 1);
                chk("pu_ready_e20", tx_ready, early ? 0 : 1);
                tx_valid = 1'b0;
            end
            if (k == 21) chk("pu_vcc_e21", vcc_en, 1);
        end
    endtask

    initial begin
        longint     acc[3];
        logic [7:0] b2b[3];
        int         lo, rdy_c, t;
        logic [7:0] rb;
        logic       rd;

        rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; tx_dc = 1'b0; vcc_req = 1'b1;
        repeat (3) @(posedge clk);
        // Early request: valid held from the first edge, accepted at edge 20.
        tx_valid = 1'b1; tx_data = 8'h5A; tx_dc = 1'b0;
        #2 rst = 1'b0;
        powerup(1'b1);
        wait_ready("early");

        // Single command byte, with vcc_req dropped mid-byte.
        send_byte(8'hAF, 1'b0);
        lo = 0; rdy_c = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (cs == 1'b0) lo++;
            if (rdy_c < 0 && tx_ready) rdy_c = c;
            if (c == 10) begin
                chk("vcc_before_drop", vcc_en, 1);
                vcc_req = 1'b0;
            end
            if (c == 11) chk("vcc_after_drop", vcc_en, 0);
        end
        chk("cmd_cs_low_cycles", lo, 34);
        chk("cmd_next_accept_edge", rdy_c + 1, 36);
        vcc_req = 1'b1;

        // Back-to-back data bytes with tx_valid held high.
        b2b[0] = 8'h12; b2b[1] = 8'h34; b2b[2] = 8'h56;
        wait_ready("b2b");
        tx_dc = 1'b1; tx_valid = 1'b1;
        for (int b = 0; b < 3; b++) begin
            tx_data = b2b[b];
            t = 0;
            while (!tx_ready && t < 100) begin
                @(negedge clk);
                t++;
            end
            chk("b2b_ready", tx_ready, 1);
            @(posedge clk);
            acc[b] = longint'($time);
            #2;
        end
        tx_valid = 1'b0;
        chk("b2b_spacing_1", int'((acc[1] - acc[0]) / 10), 36);
        chk("b2b_spacing_2", int'((acc[2] - acc[1]) / 10), 36);

        // Randomized bytes, gaps and vcc_req activity.
        for (int r = 0; r < NRAND; r++) begin
            repeat ($urandom_range(0, 4)) @(negedge clk);
            if ($urandom_range(0, 3) == 0) vcc_req = ~vcc_req;
            rb = 8'($urandom);
            rd = 1'($urandom_range(0, 1));
            send_byte(rb, rd);
        end

        // Asynchronous reset after the third rising sclk edge.
        wait_ready("pre_abort");
        vcc_req = 1'b1;
        send_byte(8'hC3, 1'b1);
        t = 0;
        while (mon_bits < 3 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("abort_third_rise", mon_bits, 3);
        #1 rst = 1'b1;
        #1;
        chk("rst_cs", cs, 1);
        chk("rst_sclk", sclk, 1);
        chk("rst_pmoden", pmoden, 0);
        chk("rst_res_n", res_n, 1);
        chk("rst_tx_ready", tx_ready, 0);
        chk("rst_init_done", init_done, 0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        powerup(1'b0);

        send_byte(8'h3C, 1'b0);
        wait_ready("final");
        repeat (5) @(negedge clk);
        chk("frames_total", frames, 6 + NRAND);
        chk("expected_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
